mux8cross_1: RTL and testbench

Registered 8-to-1 multiplexer with cross-ordered select bits: s0 is the MSB of the select index and s2 is the LSB. It picks one of eight data inputs, a0..a7, and registers the result on the clock. It also registers a one-hot decode of the select for downstream status and debug. It is a leaf datapath block used wherever a 3-bit-selected source choice feeds synchronous logic.

---
 rtl/mux8cross_1.sv | 77 +++++++
 tb/tb_mux8cross_1.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/mux8cross_1.sv
// Registered 8-to-1 multiplexer whose select is formed as {s0, s1, s2}, with s0 as the MSB.
// Alongside the data it registers a one-hot decode of the select for status and debug.
module mux8cross_1 #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] a2,
  input  logic [WIDTH-1:0] a3,
  input  logic [WIDTH-1:0] a4,
  input  logic [WIDTH-1:0] a5,
  input  logic [WIDTH-1:0] a6,
  input  logic [WIDTH-1:0] a7,
  input  logic             s0,
  input  logic             s1,
  input  logic             s2,
  output logic [WIDTH-1:0] y,
  output logic [7:0]       sel_onehot
);

  logic [2:0]       idx_s;
  logic [WIDTH-1:0] mux_s;
  logic [7:0]       onehot_s;

  function automatic logic [7:0] decode3(input logic [2:0] idx);
    logic [7:0] dec;
    case (idx)
      3'd0:    dec = 8'h01;
      3'd1:    dec = 8'h02;
      3'd2:    dec = 8'h04;
      3'd3:    dec = 8'h08;
      3'd4:    dec = 8'h10;
      3'd5:    dec = 8'h20;
      3'd6:    dec = 8'h40;
      3'd7:    dec = 8'h80;
      default: dec = 8'h00;
    endcase
    return dec;
  endfunction

  assign idx_s = {s0, s1, s2};

  // Only the addressed input reaches mux_s, so unknowns on the other inputs cannot leak into y
  always_comb begin
    mux_s    = {WIDTH{1'b0}};
    onehot_s = decode3(idx_s);
    case (idx_s)
      3'd0:    mux_s = a0;
      3'd1:    mux_s = a1;
      3'd2:    mux_s = a2;
      3'd3:    mux_s = a3;
      3'd4:    mux_s = a4;
      3'd5:    mux_s = a5;
      3'd6:    mux_s = a6;
      3'd7:    mux_s = a7;
      default: mux_s = {WIDTH{1'b0}};
    endcase
  end

  // Output registers: async clear, capture on en, otherwise hold
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y          <= {WIDTH{1'b0}};
      sel_onehot <= 8'h00;
    end else if (en) begin
      y          <= mux_s;
      sel_onehot <= onehot_s;
    end else begin
      y          <= y;
      sel_onehot <= sel_onehot;
    end
  end

endmodule

// File: tb/tb_mux8cross_1.sv
// Self-checking bench for mux8cross_1: a WIDTH=1 and a WIDTH=8 instance share clock, reset, enable
// and select, and both are compared against an array-indexed reference model of the selection.
module tb_mux8cross_1;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic       s0, s1, s2;
  logic [0:0] d1 [8];
  logic [7:0] d8 [8];
  logic [0:0] y1;
  logic [7:0] y8;
  logic [7:0] oh1, oh8;

  logic [0:0] e_y1;
  logic [7:0] e_y8;
  logic [7:0] e_oh;

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  mux8cross_1 #(.WIDTH(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .en(en),
    .a0(d1[0]), .a1(d1[1]), .a2(d1[2]), .a3(d1[3]),
    .a4(d1[4]), .a5(d1[5]), .a6(d1[6]), .a7(d1[7]),
    .s0(s0), .s1(s1), .s2(s2), .y(y1), .sel_onehot(oh1)
  );

  mux8cross_1 #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .en(en),
    .a0(d8[0]), .a1(d8[1]), .a2(d8[2]), .a3(d8[3]),
    .a4(d8[4]), .a5(d8[5]), .a6(d8[6]), .a7(d8[7]),
    .s0(s0), .s1(s1), .s2(s2), .y(y8), .sel_onehot(oh8)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".y1"},  {7'd0, y1}, {7'd0, e_y1});
    chk({tag, ".y8"},  y8,  e_y8);
    chk({tag, ".oh1"}, oh1, e_oh);
    chk({tag, ".oh8"}, oh8, e_oh);
  endtask

  task automatic set_idx(input int i);
    s0 = ((i / 4) % 2) != 0;
    s1 = ((i / 2) % 2) != 0;
    s2 = (i % 2) != 0;
  endtask

  // Reference: what the registers must show one edge after the current inputs
  task automatic tick();
    int         k;
    logic [0:0] n_y1;
    logic [7:0] n_y8;
    logic [7:0] n_oh;
    k    = 4 * int'(s0) + 2 * int'(s1) + int'(s2);
    n_y1 = d1[k];
    n_y8 = d8[k];
    n_oh = 8'h00;
    n_oh[k] = 1'b1;
    @(posedge clk);
    #1;
    if (rst_n && en) begin
      e_y1 = n_y1;
      e_y8 = n_y8;
      e_oh = n_oh;
    end
  endtask

  task automatic clear_data();
    for (int i = 0; i < 8; i++) begin
      d1[i] = 1'b0;
      d8[i] = 8'h00;
    end
  endtask

  initial begin
    rst_n = 1'b0;
    en    = 1'b1;
    set_idx(0);
    clear_data();
    e_y1 = 1'b0;
    e_y8 = 8'h00;
    e_oh = 8'h00;

    // Reset state, held across an edge while rst_n is low
    #2;
    check_all("reset");
    tick();
    check_all("reset_held");
    rst_n = 1'b1;

    // Walking select with one-hot WIDTH=1 data and random wide data
    for (int i = 0; i < 8; i++) begin
      clear_data();
      d1[i] = 1'b1;
      for (int j = 0; j < 8; j++) d8[j] = 8'($urandom);
      set_idx(i);
      tick();
      check_all("walk");
      chk("walk.y1_one", {7'd0, y1}, 8'h01);
      chk("walk.oh_const", oh1, 8'h01 << i);
    end

    // s0 must carry weight 4: s=100 picks a4, never a1
    clear_data();
    d1[1] = 1'b1;
    d1[4] = 1'b0;
    s0 = 1'b1; s1 = 1'b0; s2 = 1'b0;
    tick();
    chk("bitorder.y_a4_0", {7'd0, y1}, 8'h00);
    chk("bitorder.oh", oh1, 8'h10);
    d1[4] = 1'b1;
    tick();
    chk("bitorder.y_a4_1", {7'd0, y1}, 8'h01);

    // Isolation: selected input low, others high, then toggled or unknown
    for (int i = 0; i < 8; i++) begin
      d1[i] = 1'b1;
      d8[i] = 8'hFF;
    end
    d1[3] = 1'b0;
    d8[3] = 8'h5A;
    set_idx(3);
    tick();
    check_all("iso");
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < 8; i++) begin
        if (i != 3) begin
          d1[i] = (r == 3) ? 1'bx : ~d1[i];
          d8[i] = (r == 3) ? 8'hxx : 8'($urandom);
        end
      end
      tick();
      chk("iso.y1_zero", {7'd0, y1}, 8'h00);
      chk("iso.y8", y8, 8'h5A);
    end

    // Enable hold and resume
    clear_data();
    d1[5] = 1'b1;
    set_idx(5);
    tick();
    check_all("en_cap");
    en = 1'b0;
    set_idx(0);
    d1[0] = 1'b0;
    d8[0] = 8'hC3;
    tick();
    check_all("en_hold");
    chk("en_hold.oh", oh1, 8'h20);
    en = 1'b1;
    tick();
    check_all("en_resume");
    chk("en_resume.oh", oh1, 8'h01);

    // Wide sweep: a_k = 8'h10 + k
    for (int i = 0; i < 8; i++) d8[i] = 8'h10 + 8'(i);
    for (int i = 0; i < 8; i++) begin
      set_idx(i);
      tick();
      check_all("wide");
      chk("wide.const", y8, 8'h10 + 8'(i));
    end

    // Async reset mid-cycle with y previously 1
    clear_data();
    d1[6] = 1'b1;
    d8[6] = 8'hA5;
    set_idx(6);
    tick();
    chk("prereset.y1", {7'd0, y1}, 8'h01);
    #2;
    rst_n = 1'b0;
    e_y1 = 1'b0;
    e_y8 = 8'h00;
    e_oh = 8'h00;
    #1;
    check_all("async_rst");
    tick();
    check_all("async_rst_held");
    rst_n = 1'b1;
    tick();
    check_all("rst_release");

    // Randomized traffic with occasional enable drops and mid-cycle resets
    for (int n = 0; n < 300; n++) begin
      en = ($urandom_range(0, 3) != 0);
      set_idx(int'($urandom_range(0, 7)));
      for (int i = 0; i < 8; i++) begin
        d1[i] = 1'($urandom);
        d8[i] = 8'($urandom);
      end
      if ($urandom_range(0, 24) == 0) begin
        #2;
        rst_n = 1'b0;
        e_y1 = 1'b0;
        e_y8 = 8'h00;
        e_oh = 8'h00;
        #1;
        check_all("rnd_rst");
        tick();
        rst_n = 1'b1;
      end else begin
        tick();
      end
      check_all("rnd");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
